// File: rtl/sm3_sched_ctrl.sv
// SM3 message-schedule controller: accepts a padded 512-bit block, launches
// the expander, waits for its schedule, then streams W[j]/W'[j] for j=0..63
// to the compression core over a valid/ready handshake.
module sm3_sched_ctrl #(
   parameter logic [9:0] WDOG_MAX = 10'd1023
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [511:0] i_blk_data,
   input  logic         i_blk_valid,
   output logic         o_blk_ready,
   output logic [511:0] o_pad_data,
   output logic         o_pad_valid,
   input  logic         i_extend_valid,
   output logic [7:0]   o_rd_addr0,
   output logic [7:0]   o_rd_addr1,
   input  logic [31:0]  i_rd_data0,
   input  logic [31:0]  i_rd_data1,
   output logic [31:0]  o_w,
   output logic [31:0]  o_wp,
   output logic [5:0]   o_round,
   output logic         o_round_last,
   output logic         o_w_valid,
   input  logic         i_cf_ready,
   output logic         o_blk_done,
   output logic         o_err
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      GUARD,
      WAIT_EXT,
      STREAM,
      DRAIN
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [6:0] k;
   logic [9:0] wdog;
   logic [1:0] guard_cnt;
   logic       accept;
   logic       load;
   logic       wdog_hit;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus the state-derived outputs and strobes.
   // The watchdog check takes priority over a late i_extend_valid so that
   // o_err fires exactly when the count reaches WDOG_MAX.
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      load        = 1'b0;
      wdog_hit    = 1'b0;
      o_blk_ready = 1'b0;
      o_pad_valid = 1'b0;
      o_rd_addr0  = '0;
      o_rd_addr1  = '0;
      case (state)
         IDLE: begin
            o_blk_ready = 1'b1;
            if (i_blk_valid) begin
               accept    = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            o_pad_valid = 1'b1;
            state_nxt   = GUARD;
         end
         GUARD: begin
            if (wdog == WDOG_MAX) begin
               wdog_hit  = 1'b1;
               state_nxt = IDLE;
            end else if (guard_cnt == 2'd3) begin
               state_nxt = WAIT_EXT;
            end
         end
         WAIT_EXT: begin
            if (wdog == WDOG_MAX) begin
               wdog_hit  = 1'b1;
               state_nxt = IDLE;
            end else if (i_extend_valid) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            o_rd_addr0 = {1'b0, k};
            o_rd_addr1 = 8'd68 + {1'b0, k};
            load       = (k <= 7'd63) && (!o_w_valid || i_cf_ready);
            if (load && (k == 7'd63)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (i_cf_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      o_err = wdog_hit;
   end

   assign o_round_last = o_w_valid && (o_round == 6'd63);

   // Block capture, guard/watchdog counters, issue index and the round-word
   // output register with its stall handling.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pad_data <= '0;
         k          <= '0;
         wdog       <= '0;
         guard_cnt  <= '0;
         o_w        <= '0;
         o_wp       <= '0;
         o_round    <= '0;
         o_w_valid  <= 1'b0;
         o_blk_done <= 1'b0;
      end else begin
         o_blk_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  o_pad_data <= i_blk_data;
               end
            end
            LAUNCH: begin
               guard_cnt <= '0;
               wdog      <= '0;
            end
            GUARD: begin
               wdog      <= wdog + 10'd1;
               guard_cnt <= guard_cnt + 2'd1;
            end
            WAIT_EXT: begin
               wdog <= wdog + 10'd1;
               if (i_extend_valid) begin
                  k <= '0;
               end
            end
            STREAM: begin
               if (load) begin
                  o_w       <= i_rd_data0;
                  o_wp      <= i_rd_data1;
                  o_round   <= k[5:0];
                  o_w_valid <= 1'b1;
                  k         <= k + 7'd1;
               end else if (o_w_valid && i_cf_ready) begin
                  o_w_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (i_cf_ready) begin
                  o_w_valid  <= 1'b0;
                  o_blk_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sm3_sched_ctrl.sv
// Bench for sm3_sched_ctrl: an expander model (memory word = offset + addr,
// stale-ready tail after each start pulse, configurable latency) and a
// transaction-level reference of what the controller must deliver per block.
module tb_sm3_sched_ctrl;

   localparam logic [9:0] WDOG = 10'd200;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b0;
   logic [511:0] i_blk_data = '0;
   logic         i_blk_valid = 1'b0;
   logic         o_blk_ready;
   logic [511:0] o_pad_data;
   logic         o_pad_valid;
   logic         i_extend_valid = 1'b0;
   logic [7:0]   o_rd_addr0;
   logic [7:0]   o_rd_addr1;
   logic [31:0]  i_rd_data0;
   logic [31:0]  i_rd_data1;
   logic [31:0]  o_w;
   logic [31:0]  o_wp;
   logic [5:0]   o_round;
   logic         o_round_last;
   logic         o_w_valid;
   logic         i_cf_ready = 1'b0;
   logic         o_blk_done;
   logic         o_err;

   sm3_sched_ctrl #(.WDOG_MAX(WDOG)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_blk_data     (i_blk_data),
      .i_blk_valid    (i_blk_valid),
      .o_blk_ready    (o_blk_ready),
      .o_pad_data     (o_pad_data),
      .o_pad_valid    (o_pad_valid),
      .i_extend_valid (i_extend_valid),
      .o_rd_addr0     (o_rd_addr0),
      .o_rd_addr1     (o_rd_addr1),
      .i_rd_data0     (i_rd_data0),
      .i_rd_data1     (i_rd_data1),
      .o_w            (o_w),
      .o_wp           (o_wp),
      .o_round        (o_round),
      .o_round_last   (o_round_last),
      .o_w_valid      (o_w_valid),
      .i_cf_ready     (i_cf_ready),
      .o_blk_done     (o_blk_done),
      .o_err          (o_err)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errs   = 0;

   // expander model state
   logic [31:0] mem_off = '0;
   logic [31:0] pend    = '0;
   logic        ext_lvl = 1'b0;
   int          stale   = 0;
   int          bcnt    = 0;
   int          lat_cfg = 4;

   // reference model of the controller's obligations
   int          cyc        = 0;
   int          acc_cyc    = 0;
   int          rise_cyc   = -1;
   int          exp_j      = 0;
   int          acc_budget = 0;
   bit          busy       = 1'b0;
   bit          acc_prev   = 1'b0;
   bit          done_prev  = 1'b0;
   bit          stall_prev = 1'b0;
   bit          started    = 1'b0;
   bit          last_hs    = 1'b0;
   bit          cf_mode    = 1'b0;
   bit          hold_valid = 1'b0;
   bit          zero_low   = 1'b0;
   logic [511:0] exp_pad   = '0;
   logic [31:0]  exp_off   = '0;
   logic [31:0]  pw        = '0;
   logic [31:0]  pwp       = '0;
   logic [5:0]   pr        = '0;

   assign i_rd_data0 = mem_off + {24'd0, o_rd_addr0};
   assign i_rd_data1 = mem_off + {24'd0, o_rd_addr1};

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_reset_outputs();
      check("rst_pad_data", o_pad_data, 512'd0);
      check("rst_ready_pv", {o_blk_ready, o_pad_valid}, 2'b10);
      check("rst_addr", {o_rd_addr0, o_rd_addr1}, 16'd0);
      check("rst_w_wp", {o_w, o_wp}, 64'd0);
      check("rst_round", {o_round, o_round_last, o_w_valid}, 8'd0);
      check("rst_done_err", {o_blk_done, o_err}, 2'b00);
   endtask

   // One clock cycle: drive inputs at the falling edge, check just after,
   // advance the reference, then let the expander react to the rising edge.
   task automatic step();
      bit          acc;
      bit          hs;
      bit          pv;
      bit          err_exp;
      int          j_now;
      int          wstart;
      int          first;
      logic [31:0] pad_lo;
      i_cf_ready     = cf_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      i_blk_valid    = busy ? hold_valid : (acc_budget > 0);
      i_blk_data     = rand512();
      if (zero_low) i_blk_data[31:0] = '0;
      i_extend_valid = ext_lvl;
      #1;
      err_exp = busy && (lat_cfg < 0) && (cyc - acc_cyc - 2 == int'(WDOG));
      check("pad_data", o_pad_data, exp_pad);
      check("pad_valid", o_pad_valid, acc_prev);
      check("blk_ready", o_blk_ready, !busy);
      check("blk_done", o_blk_done, done_prev);
      check("err", o_err, err_exp);
      if (!busy) check("idle_addr", {o_rd_addr0, o_rd_addr1}, 16'd0);
      if (stall_prev) check("stall_hold", {o_w_valid, o_w, o_wp, o_round}, {1'b1, pw, pwp, pr});
      if (busy && !started) begin
         wstart = acc_cyc + 6;
         first  = (rise_cyc >= 0) ? (((rise_cyc > wstart) ? rise_cyc : wstart) + 2) : -1;
         check("stream_start", o_w_valid, cyc == first);
         if (o_w_valid) started = 1'b1;
      end else if (busy && !cf_mode && !last_hs) begin
         check("no_bubble", o_w_valid, 1'b1);
      end
      hs    = o_w_valid && i_cf_ready;
      j_now = exp_j;
      if (hs) begin
         check("hs_round", {1'b0, o_round}, 7'(exp_j));
         check("hs_w", o_w, exp_off + 32'(exp_j));
         check("hs_wp", o_wp, exp_off + 32'(68 + exp_j));
         check("hs_last", o_round_last, exp_j == 63);
         exp_j++;
      end
      acc    = i_blk_valid && !busy;
      pv     = o_pad_valid;
      pad_lo = o_pad_data[31:0];
      done_prev = hs && (j_now == 63);
      if (done_prev) begin
         last_hs = 1'b1;
         busy    = 1'b0;
      end
      if (err_exp) busy = 1'b0;
      acc_prev = acc;
      if (acc) begin
         busy     = 1'b1;
         acc_budget--;
         exp_pad  = i_blk_data;
         exp_off  = i_blk_data[31:0];
         exp_j    = 0;
         started  = 1'b0;
         last_hs  = 1'b0;
         rise_cyc = -1;
         acc_cyc  = cyc;
      end
      stall_prev = o_w_valid && !i_cf_ready;
      pw  = o_w;
      pwp = o_wp;
      pr  = o_round;
      cyc++;
      @(posedge i_clk);
      if (pv) begin
         stale = ext_lvl ? 3 : 0;
         bcnt  = lat_cfg;
         pend  = pad_lo;
      end else begin
         if (stale > 0) begin
            stale--;
            if (stale == 0) ext_lvl = 1'b0;
         end
         if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) begin
               ext_lvl  = 1'b1;
               mem_off  = pend;
               rise_cyc = cyc;
            end
         end
      end
      @(negedge i_clk);
   endtask

   task automatic run_blocks(input int nblk, input int lim);
      int c;
      c = 0;
      acc_budget = nblk;
      while ((busy || acc_budget > 0) && c < lim) begin
         step();
         c++;
      end
      check("timeout", c < lim, 1'b1);
      step();
   endtask

   initial begin
      int c;
      // reset state
      #1 i_rst = 1'b1;
      #1;
      check_reset_outputs();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;

      // single block, core always ready, W[a]=a
      cf_mode = 1'b0; hold_valid = 1'b0; zero_low = 1'b1; lat_cfg = 6;
      run_blocks(1, 300);

      // back-to-back with the previous ready level still high
      zero_low = 1'b0; lat_cfg = 3;
      run_blocks(1, 300);

      // randomly throttled core
      cf_mode = 1'b1;
      for (int b = 0; b < 3; b++) begin
         lat_cfg = $urandom_range(3, 10);
         run_blocks(1, 800);
      end

      // block valid held high and data churning during the whole block
      hold_valid = 1'b1; lat_cfg = 5;
      run_blocks(1, 800);
      hold_valid = 1'b0;

      // expander never becomes ready: watchdog error
      cf_mode = 1'b0; lat_cfg = -1;
      run_blocks(1, int'(WDOG) + 50);
      step();

      // reset in the middle of streaming at round 30
      lat_cfg = 4; acc_budget = 1;
      c = 0;
      while (exp_j < 30 && c < 300) begin
         step();
         c++;
      end
      check("timeout_r30", c < 300, 1'b1);
      check("pre_rst_round", {o_w_valid, o_round}, {1'b1, 6'd30});
      i_rst = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst      = 1'b0;
      busy       = 1'b0;
      acc_prev   = 1'b0;
      done_prev  = 1'b0;
      stall_prev = 1'b0;
      started    = 1'b0;
      last_hs    = 1'b0;
      acc_budget = 0;
      exp_pad    = '0;
      repeat (4) step();
      lat_cfg = $urandom_range(3, 10);
      run_blocks(1, 300);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
